// File: rtl/contador_modular.sv
// Generic modulo-MODULO timebase counter with prescaler, up/down, parallel load and optional saturation.
// Default parameters give the 0,1,2,3,4,0,... sequence.
module contador_modular #(
   parameter int WIDTH    = 3,
   parameter int MODULO   = 5,
   parameter int PRESCALE = 1,
   parameter int PS_WIDTH = 4,
   parameter int SATURATE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] S,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0]    S_MAX   = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0]    S_ONE   = WIDTH'(1);
   localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
   localparam logic [PS_WIDTH-1:0] PS_ONE  = PS_WIDTH'(1);

   logic [PS_WIDTH-1:0] ps_cnt;
   logic [PS_WIDTH-1:0] ps_nxt;
   logic [WIDTH-1:0]    s_nxt;
   logic                wrap_nxt;
   logic                lerr_nxt;

   always_comb begin
      s_nxt    = S;
      ps_nxt   = ps_cnt;
      wrap_nxt = 1'b0;
      lerr_nxt = 1'b0;
      if (load) begin
         ps_nxt = '0;
         // Out-of-range loads park S at 0 so it can never leave 0..MODULO-1.
         if (load_value <= S_MAX) begin
            s_nxt = load_value;
         end else begin
            s_nxt    = '0;
            lerr_nxt = 1'b1;
         end
      end else if (enable) begin
         if (ps_cnt == PS_LAST) begin
            ps_nxt = '0;
            if (up) begin
               if (S == S_MAX) begin
                  if (SATURATE == 0) begin
                     s_nxt    = '0;
                     wrap_nxt = 1'b1;
                  end
               end else begin
                  s_nxt = S + S_ONE;
               end
            end else begin
               if (S == '0) begin
                  if (SATURATE == 0) begin
                     s_nxt    = S_MAX;
                     wrap_nxt = 1'b1;
                  end
               end else begin
                  s_nxt = S - S_ONE;
               end
            end
         end else begin
            ps_nxt = ps_cnt + PS_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         S        <= '0;
         ps_cnt   <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         S        <= s_nxt;
         ps_cnt   <= ps_nxt;
         wrap     <= wrap_nxt;
         load_err <= lerr_nxt;
      end
   end

   assign tc = (up && (S == S_MAX)) || (!up && (S == '0));

endmodule

// File: tb/tb_contador_modular.sv
// Bench for contador_modular: vector table on the default build, directed sequences for the
// prescaled and saturating builds, and a reference model run on a MODULO=10 build.
module tb_contador_modular;

   logic       clock;
   logic       reset, enable, up, load;
   logic [2:0] lv3;
   logic [3:0] lv4;

   logic [2:0] s_a, s_p, s_s;
   logic [3:0] s_w;
   logic       tc_a, wr_a, le_a;
   logic       tc_p, wr_p, le_p;
   logic       tc_s, wr_s, le_s;
   logic       tc_w, wr_w, le_w;

   int checks = 0;
   int errors = 0;

   contador_modular dut_a (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(lv3), .S(s_a), .tc(tc_a), .wrap(wr_a), .load_err(le_a));

   contador_modular #(.PRESCALE(3)) dut_p (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(lv3), .S(s_p), .tc(tc_p), .wrap(wr_p), .load_err(le_p));

   contador_modular #(.SATURATE(1)) dut_s (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(lv3), .S(s_s), .tc(tc_s), .wrap(wr_s), .load_err(le_s));

   contador_modular #(.WIDTH(4), .MODULO(10), .PRESCALE(2)) dut_w (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_value(lv4), .S(s_w), .tc(tc_w), .wrap(wr_w), .load_err(le_w));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rst, en, dir, ld;
      logic [2:0] lv;
      logic [2:0] s;
      logic       tc, wr, le;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic rst, logic en, logic dir, logic ld, logic [2:0] lv,
                               logic [2:0] s, logic t, logic w, logic e);
      vec_t v;
      v.rst = rst; v.en = en; v.dir = dir; v.ld = ld; v.lv = lv;
      v.s = s; v.tc = t; v.wr = w; v.le = e;
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0d required=%0d", name, idx, act, exp);
      end
   endtask

   // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic cyc(logic rst, logic en, logic dir, logic ld, logic [2:0] l3, logic [3:0] l4);
      reset = rst; enable = en; up = dir; load = ld; lv3 = l3; lv4 = l4;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Reference state for the MODULO=10, PRESCALE=2 build
   int m_s, m_ps;
   bit m_wr, m_le;

   initial begin
      logic [2:0] exp_p[12];
      logic [2:0] exp_s[14];
      reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; lv3 = '0; lv4 = '0;

      // Test 1: count up with wrap
      add(1,0,1,0,0, 0,0,0,0);
      add(0,1,1,0,0, 1,0,0,0); add(0,1,1,0,0, 2,0,0,0); add(0,1,1,0,0, 3,0,0,0);
      add(0,1,1,0,0, 4,1,0,0); add(0,1,1,0,0, 0,0,1,0); add(0,1,1,0,0, 1,0,0,0);
      add(0,1,1,0,0, 2,0,0,0); add(0,1,1,0,0, 3,0,0,0); add(0,1,1,0,0, 4,1,0,0);
      add(0,1,1,0,0, 0,0,1,0); add(0,1,1,0,0, 1,0,0,0); add(0,1,1,0,0, 2,0,0,0);
      // Test 2: count down with wrap, then hold clears wrap
      add(1,0,0,0,0, 0,1,0,0);
      add(0,1,0,0,0, 4,0,1,0); add(0,1,0,0,0, 3,0,0,0); add(0,1,0,0,0, 2,0,0,0);
      add(0,1,0,0,0, 1,0,0,0); add(0,1,0,0,0, 0,1,0,0); add(0,1,0,0,0, 4,0,1,0);
      add(0,0,0,0,0, 4,0,0,0);
      // Test 3: loads, load errors, reset priority
      add(0,1,1,1,3, 3,0,0,0); add(0,1,1,0,0, 4,1,0,0); add(0,1,1,1,6, 0,0,0,1);
      add(0,0,1,0,0, 0,0,0,0); add(0,0,1,1,4, 4,1,0,0); add(1,1,1,1,2, 0,0,0,0);
      add(0,0,0,1,5, 0,1,0,1); add(0,1,0,1,7, 0,1,0,1); add(0,1,0,0,0, 4,0,1,0);
      add(0,1,1,1,1, 1,0,0,0);

      @(negedge clock);
      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].en, tbl[i].dir, tbl[i].ld, tbl[i].lv, 4'd0);
         chk("tbl_S",    i, 8'(s_a),  8'(tbl[i].s));
         chk("tbl_tc",   i, 8'(tc_a), 8'(tbl[i].tc));
         chk("tbl_wrap", i, 8'(wr_a), 8'(tbl[i].wr));
         chk("tbl_lerr", i, 8'(le_a), 8'(tbl[i].le));
      end

      // Test 4: PRESCALE=3 build, pause at ps_cnt=1 then resume
      exp_p = '{0,0,1,1,1,2,2,2,2,2,2,2};
      cyc(1,0,1,0,0,0);
      chk("ps_reset", 0, 8'(s_p), 8'd0);
      for (int i = 0; i < 7; i++) begin
         cyc(0,1,1,0,0,0);
         chk("ps_S", i, 8'(s_p), 8'(exp_p[i]));
         chk("ps_wrap", i, 8'(wr_p), 8'd0);
      end
      for (int i = 7; i < 12; i++) begin
         cyc(0,0,1,0,0,0);
         chk("ps_hold", i, 8'(s_p), 8'(exp_p[i]));
      end
      cyc(0,1,1,0,0,0);
      chk("ps_resume1", 0, 8'(s_p), 8'd2);
      cyc(0,1,1,0,0,0);
      chk("ps_resume2", 0, 8'(s_p), 8'd3);
      // Reset mid-count discards prescaler progress
      cyc(0,1,1,0,0,0);
      cyc(1,1,1,0,0,0);
      chk("ps_rst_S", 0, 8'(s_p), 8'd0);
      cyc(0,1,1,0,0,0); cyc(0,1,1,0,0,0);
      chk("ps_rst_phase", 0, 8'(s_p), 8'd0);
      cyc(0,1,1,0,0,0);
      chk("ps_rst_step", 0, 8'(s_p), 8'd1);

      // Test 5: SATURATE=1 build
      exp_s = '{1,2,3,4,4,4,4,4, 3,2,1,0,0,0};
      cyc(1,0,1,0,0,0);
      for (int i = 0; i < 14; i++) begin
         cyc(0,1,(i < 8),0,0,0);
         chk("sat_S", i, 8'(s_s), 8'(exp_s[i]));
         chk("sat_wrap", i, 8'(wr_s), 8'd0);
         chk("sat_tc", i, 8'(tc_s),
             8'(((i < 8) && exp_s[i] == 3'd4) || ((i >= 8) && exp_s[i] == 3'd0)));
      end

      // Test 6: MODULO=10 build against a reference model
      cyc(1,0,1,0,0,0);
      m_s = 0; m_ps = 0; m_wr = 0; m_le = 0;
      for (int i = 0; i < 2000; i++) begin
         logic r, e, d, l;
         logic [3:0] v;
         r = ($urandom_range(99) < 2);
         e = ($urandom_range(99) < 75);
         d = $urandom_range(1);
         l = ($urandom_range(99) < 10);
         v = 4'($urandom_range(15));
         cyc(r, e, d, l, 3'd0, v);
         m_wr = 0; m_le = 0;
         if (r) begin
            m_s = 0; m_ps = 0;
         end else if (l) begin
            m_ps = 0;
            if (int'(v) < 10) m_s = int'(v);
            else begin m_s = 0; m_le = 1; end
         end else if (e) begin
            if (m_ps == 1) begin
               m_ps = 0;
               if (d) begin
                  m_wr = (m_s == 9);
                  m_s = (m_s + 1) % 10;
               end else begin
                  m_wr = (m_s == 0);
                  m_s = (m_s + 9) % 10;
               end
            end else begin
               m_ps = m_ps + 1;
            end
         end
         chk("rnd_S", i, 8'(s_w), 8'(m_s));
         chk("rnd_tc", i, 8'(tc_w), 8'((d && m_s == 9) || (!d && m_s == 0)));
         chk("rnd_wrap", i, 8'(wr_w), 8'(m_wr));
         chk("rnd_lerr", i, 8'(le_w), 8'(m_le));
         chk("rnd_range", i, 8'(s_w < 4'd10), 8'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
